// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receive types, constants and the data-width decode helper.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, RESYNC} rx_state_t;

    typedef enum logic [1:0] {BITS5, BITS6, BITS7, BITS8} data_bits_t;

    localparam int DEFAULT_OVERSAMPLE = 16;

    function automatic logic [3:0] data_bits_to_n(input data_bits_t b);
        return 4'(b) + 4'd5;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: multi-flop synchronizer for asynchronous inputs that idle high.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] ff;

    always_ff @(posedge clk)
        ff <= reset ? '1 : {ff[SYNC_STAGES-2:0], d};

    assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: oversampled UART receive framer feeding the RX FIFO,
// with parity, framing, break and overrun reporting.
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = DEFAULT_OVERSAMPLE,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable_i,
    input  logic       baud_tick_i,
    input  logic       rx_i,
    input  logic [1:0] cfg_data_bits_i,
    input  logic       cfg_parity_en_i,
    input  logic       cfg_parity_odd_i,
    input  logic       cfg_stop2_i,
    input  logic       fifo_rx_full_i,
    output logic [7:0] fifo_rx_data_o,
    output logic       fifo_rx_push_o,
    output logic       parity_err_o,
    output logic       frame_err_o,
    output logic       break_o,
    output logic       overrun_o,
    output logic       rx_busy_o
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] START_PT = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] BIT_PT   = CW'(OVERSAMPLE - 1);

    rx_state_t   state;
    logic        rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]  idx;
    logic [7:0]  shreg;
    logic [3:0]  n;
    logic        par_en, par_odd, stop2, stop_idx, stop1, par_bit, par_err;
    logic        sample, first_stop, fe, brk;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (rx_i),
        .q    (rx_s)
    );

    assign sample     = baud_tick_i && cnt == BIT_PT;
    assign first_stop = stop_idx ? stop1 : rx_s;
    assign fe         = !first_stop || !rx_s;
    assign brk        = shreg == 8'h00 && !par_bit && !first_stop;
    assign rx_busy_o  = state != IDLE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            idx            <= '0;
            shreg          <= '0;
            n              <= 4'd5;
            par_en         <= 1'b0;
            par_odd        <= 1'b0;
            stop2          <= 1'b0;
            stop_idx       <= 1'b0;
            stop1          <= 1'b0;
            par_bit        <= 1'b0;
            par_err        <= 1'b0;
            fifo_rx_data_o <= '0;
            fifo_rx_push_o <= 1'b0;
            parity_err_o   <= 1'b0;
            frame_err_o    <= 1'b0;
            break_o        <= 1'b0;
            overrun_o      <= 1'b0;
        end else begin
            fifo_rx_push_o <= 1'b0;
            parity_err_o   <= 1'b0;
            frame_err_o    <= 1'b0;
            break_o        <= 1'b0;
            overrun_o      <= 1'b0;
            if (baud_tick_i)
                cnt <= cnt + 1'b1;
            if (!enable_i) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: if (baud_tick_i && !rx_s) begin
                        state    <= START;
                        cnt      <= '0;
                        idx      <= '0;
                        shreg    <= '0;
                        stop_idx <= 1'b0;
                        par_bit  <= 1'b0;
                        par_err  <= 1'b0;
                        n        <= data_bits_to_n(data_bits_t'(cfg_data_bits_i));
                        par_en   <= cfg_parity_en_i;
                        par_odd  <= cfg_parity_odd_i;
                        stop2    <= cfg_stop2_i;
                    end
                    START: if (baud_tick_i && cnt == START_PT) begin
                        state <= rx_s ? IDLE : DATA;
                        cnt   <= '0;
                    end
                    DATA: if (sample) begin
                        shreg[idx] <= rx_s;
                        idx        <= idx + 1'b1;
                        if (idx == 3'(n - 4'd1)) begin
                            state <= par_en ? PARITY : STOP;
                            cnt   <= '0;
                        end
                    end
                    PARITY: if (sample) begin
                        par_bit <= rx_s;
                        par_err <= (^shreg ^ rx_s) != par_odd;
                        state   <= STOP;
                        cnt     <= '0;
                    end
                    STOP: if (sample) begin
                        if (stop2 && !stop_idx) begin
                            stop_idx <= 1'b1;
                            stop1    <= rx_s;
                        end else begin
                            // A low final stop means the line is still low: hold off new starts.
                            state <= rx_s ? IDLE : RESYNC;
                            cnt   <= '0;
                            if (fifo_rx_full_i)
                                overrun_o <= 1'b1;
                            else begin
                                fifo_rx_push_o <= 1'b1;
                                fifo_rx_data_o <= shreg;
                                parity_err_o   <= par_err;
                                frame_err_o    <= fe;
                                break_o        <= brk;
                            end
                        end
                    end
                    RESYNC: if (baud_tick_i && rx_s) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer: randomized and directed frames checked by a queue-based scoreboard.
module tb_uart_rx_deserializer;

    localparam int BIT_CLK = 64;

    typedef struct packed {
        logic       push;
        logic       ovr;
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       brk;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable_i = 1'b1;
    logic       baud_tick_i = 1'b0;
    logic       rx_i = 1'b1;
    logic [1:0] cfg_data_bits_i = 2'd3;
    logic       cfg_parity_en_i = 1'b0;
    logic       cfg_parity_odd_i = 1'b0;
    logic       cfg_stop2_i = 1'b0;
    logic       fifo_rx_full_i = 1'b0;
    logic [7:0] fifo_rx_data_o;
    logic       fifo_rx_push_o, parity_err_o, frame_err_o, break_o, overrun_o, rx_busy_o;

    int   errors = 0;
    int   checks = 0;
    exp_t q[$];

    uart_rx_deserializer dut (
        .clk             (clk),
        .reset           (reset),
        .enable_i        (enable_i),
        .baud_tick_i     (baud_tick_i),
        .rx_i            (rx_i),
        .cfg_data_bits_i (cfg_data_bits_i),
        .cfg_parity_en_i (cfg_parity_en_i),
        .cfg_parity_odd_i(cfg_parity_odd_i),
        .cfg_stop2_i     (cfg_stop2_i),
        .fifo_rx_full_i  (fifo_rx_full_i),
        .fifo_rx_data_o  (fifo_rx_data_o),
        .fifo_rx_push_o  (fifo_rx_push_o),
        .parity_err_o    (parity_err_o),
        .frame_err_o     (frame_err_o),
        .break_o         (break_o),
        .overrun_o       (overrun_o),
        .rx_busy_o       (rx_busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        int k = 0;
        forever begin
            @(negedge clk);
            k++;
            baud_tick_i = (k % 4 == 0);
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Expected FIFO-side effect of one character, from the framing rules.
    function automatic exp_t model(input logic [7:0] d, input logic [1:0] nb, input logic pen,
                                   input logic podd, input logic st2, input logic pbit,
                                   input logic s1, input logic s2, input logic full);
        int         n;
        logic [7:0] dm;
        exp_t       e;
        n  = nb + 5;
        dm = d & 8'((1 << n) - 1);
        e.push = !full;
        e.ovr  = full;
        e.d    = full ? 8'h00 : dm;
        e.pe   = !full && pen && ((^dm ^ pbit) != podd);
        e.fe   = !full && (!s1 || (st2 && !s2));
        e.brk  = !full && dm == 8'h00 && (!pen || !pbit) && !s1;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic bits(input int nb);
        repeat (nb * BIT_CLK) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic [1:0] nb, input logic pen, input logic podd,
                        input logic st2, input logic pflip, input logic s1, input logic s2,
                        input logic full, input logic chg);
        int   n;
        logic pbit;
        n    = nb + 5;
        pbit = ^(d & 8'((1 << n) - 1)) ^ podd ^ pflip;
        q.push_back(model(d, nb, pen, podd, st2, pbit, s1, s2, full));
        cfg_data_bits_i  = nb;
        cfg_parity_en_i  = pen;
        cfg_parity_odd_i = podd;
        cfg_stop2_i      = st2;
        fifo_rx_full_i   = full;
        rx_i = 1'b0;
        bits(1);
        if (chg)
            cfg_data_bits_i = 2'd3;
        for (int i = 0; i < n; i++) begin
            rx_i = d[i];
            bits(1);
            if (i == 0)
                chk("busy_mid_frame", 32'(rx_busy_o), 32'd1);
        end
        if (pen) begin
            rx_i = pbit;
            bits(1);
        end
        rx_i = s1;
        bits(1);
        if (st2) begin
            rx_i = s2;
            bits(1);
        end
        rx_i = 1'b1;
        bits(2);
        fifo_rx_full_i = 1'b0;
        chk("busy_after_frame", 32'(rx_busy_o), 32'd0);
    endtask

    // Scoreboard monitor: every push or overrun pops one expectation.
    initial begin
        exp_t e, got;
        logic prev_push = 1'b0;
        forever begin
            @(negedge clk);
            if (fifo_rx_push_o && prev_push) begin
                checks++;
                errors++;
                $display("FAIL push_back_to_back");
            end
            prev_push = fifo_rx_push_o;
            got = '{fifo_rx_push_o, overrun_o, fifo_rx_push_o ? fifo_rx_data_o : 8'h00,
                    parity_err_o, frame_err_o, break_o};
            if (fifo_rx_push_o || overrun_o) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output got=%h", got);
                end else begin
                    e = q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL frame got push=%0d ovr=%0d d=%02h pe=%0d fe=%0d brk=%0d exp push=%0d ovr=%0d d=%02h pe=%0d fe=%0d brk=%0d",
                                 got.push, got.ovr, got.d, got.pe, got.fe, got.brk,
                                 e.push, e.ovr, e.d, e.pe, e.fe, e.brk);
                    end
                end
            end else if (parity_err_o || frame_err_o || break_o) begin
                checks++;
                errors++;
                $display("FAIL stray_pulse got pe=%0d fe=%0d brk=%0d", parity_err_o, frame_err_o, break_o);
            end
        end
    end

    initial begin
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_outputs", 32'({fifo_rx_data_o, fifo_rx_push_o, parity_err_o, frame_err_o,
                                  break_o, overrun_o, rx_busy_o}), 32'd0);
        bits(1);

        send(8'hA5, 2'd3, 0, 0, 0, 0, 1, 1, 0, 0);
        send(8'h35, 2'd2, 1, 0, 1, 0, 1, 1, 0, 0);
        send(8'h35, 2'd2, 1, 0, 1, 1, 1, 1, 0, 0);

        rx_i = 1'b0;
        repeat (8) @(negedge clk);
        rx_i = 1'b1;
        repeat (48) @(negedge clk);
        chk("glitch_idle", 32'(rx_busy_o), 32'd0);
        bits(1);

        cfg_data_bits_i  = 2'd3;
        cfg_parity_en_i  = 1'b1;
        cfg_parity_odd_i = 1'b1;
        cfg_stop2_i      = 1'b0;
        q.push_back(model(8'h00, 2'd3, 1, 1, 0, 0, 0, 0, 0));
        rx_i = 1'b0;
        bits(20);
        chk("break_queue_drained", 32'(q.size()), 32'd0);
        rx_i = 1'b1;
        bits(2);
        chk("break_resync_idle", 32'(rx_busy_o), 32'd0);
        send(8'h5A, 2'd3, 1, 1, 0, 0, 1, 1, 0, 0);

        send(8'h3C, 2'd3, 0, 0, 0, 0, 1, 1, 1, 0);
        send(8'hC3, 2'd3, 0, 0, 0, 0, 1, 1, 0, 0);

        send(8'h1F, 2'd0, 0, 0, 0, 0, 1, 1, 0, 1);

        cfg_data_bits_i = 2'd3;
        cfg_parity_en_i = 1'b0;
        cfg_stop2_i     = 1'b0;
        rx_i = 1'b0;
        bits(1);
        rx_i = 1'b1;
        bits(2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_mid_frame", 32'({fifo_rx_data_o, fifo_rx_push_o, parity_err_o, frame_err_o,
                                    break_o, overrun_o, rx_busy_o}), 32'd0);
        bits(10);

        for (int i = 0; i < 20; i++) begin
            send(8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(3) == 0, $urandom_range(7) != 0, $urandom_range(7) != 0,
                 $urandom_range(7) == 0, 1'b0);
        end

        for (int i = 0; i < 2000 && q.size() != 0; i++)
            @(negedge clk);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
